traffic_phase_timer: RTL and testbench
======================================

TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

Interface
REQ-001 Parameter G_T, default 4'd10: green phase duration in 1 s ticks.
REQ-002 Parameter Y_T, default 4'd5: yellow phase duration in 1 s ticks.
REQ-003 Parameter R_T, default 4'd15: red phase duration in 1 s ticks.
REQ-004 sys_clk  input  1  system clock; all state on rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-high; clock sys_clk.
REQ-006 sys_clk_1s  input  1  free-running 1 Hz level from a slow clock domain; sampled, never used as a clock.
REQ-007 light_ctrl  input  3  current controller phase, one-hot: bit0 G, bit1 Y, bit2 R, 3'b000 IDLE.
REQ-008 light_t  output  4  remaining seconds of current phase, fed back to the controller.
REQ-009 phase_done  output  1  one-cycle pulse when light_t reaches 1 by countdown.
REQ-010 ctrl_err  output  1  sticky flag: illegal light_ctrl code seen.

Function
REQ-011 sys_clk_1s SHALL pass a 2-flop synchronizer, then a rising-edge detector producing a one-cycle tick.
REQ-012 A sys_clk_1s rising edge sampled at edge n SHALL produce tick at edge n+2 and the light_t decrement at edge n+3.
REQ-013 Registered copy ctrl_q of light_ctrl SHALL be kept; light_ctrl != ctrl_q SHALL be a phase change.
REQ-014 On phase change, light_t SHALL load next cycle: G->G_T, Y->Y_T, R->R_T, IDLE->4'd1.
REQ-015 A duration parameter of 0 SHALL be loaded as 4'd1.
REQ-016 On tick with no phase change: light_t > 1 -> decrement by 1; light_t == 1 -> hold at 1.
REQ-017 phase_done SHALL pulse high one cycle exactly when a tick decrements light_t from 2 to 1; never on load.
REQ-018 Phase change and tick in the same cycle: load SHALL win, tick discarded.
REQ-019 light_t SHALL never wrap below 1 or exceed 15.
REQ-020 Illegal light_ctrl (more than one bit set) SHALL load 4'd1, set ctrl_err, and hold until a legal code arrives.
REQ-021 ctrl_err SHALL clear only on reset.
REQ-022 IDLE with light_t == 1 SHALL hold; ticks in IDLE SHALL not pulse phase_done.

Reset
REQ-023 Reset SHALL force light_t = 4'd1, phase_done = 0, ctrl_err = 0, ctrl_q = 3'b000, synchronizer and edge flops = 0.
REQ-024 Reset asserted mid-countdown SHALL take effect immediately and asynchronously; countdown SHALL restart from REQ-014 rules after release.
REQ-025 The first sys_clk_1s high sampled after reset SHALL count as a rising edge only if the synchronized level was low at least one cycle.

Configuration
REQ-026 Macro TRAFFIC_TIMER_BCD_EN defined: extra outputs disp_tens[3:0] and disp_ones[3:0] SHALL give BCD of light_t, registered, one cycle after light_t.
REQ-027 TRAFFIC_TIMER_BCD_EN undefined: those ports and their logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-028 Package traffic_pkg SHALL hold phase one-hot constants (PH_IDLE, PH_G, PH_Y, PH_R) and default durations.
REQ-029 Sub-module tick_sync SHALL implement the synchronizer and edge detector (REQ-011, REQ-012, REQ-025).
REQ-030 Countdown, load and error logic SHALL reside in traffic_phase_timer.

Verification
REQ-031 Reset, light_ctrl = 3'b000, 5 ticks -> light_t stays 1, phase_done never high.
REQ-032 light_ctrl 000->001, 9 ticks -> light_t 10,9..2,1; phase_done one pulse at 2->1; tenth tick holds 1.
REQ-033 Change light_ctrl 001->010 in the same cycle as a tick -> light_t = 5 next cycle, no decrement.
REQ-034 light_ctrl = 3'b011 -> light_t = 1, ctrl_err = 1; then 3'b100 -> light_t = 15, ctrl_err stays 1.
REQ-035 Assert reset at light_t = 7 in red -> light_t = 1 immediately, ctrl_err = 0; release with light_ctrl = 100 -> loads 15.
REQ-036 With TRAFFIC_TIMER_BCD_EN, light_t = 12 -> disp_tens = 1, disp_ones = 2 one cycle later.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic phase timer: one-hot phase codes,
// default phase durations and small decode helpers.
package traffic_pkg;

    localparam logic [2:0] PH_IDLE = 3'b000;
    localparam logic [2:0] PH_G    = 3'b001;
    localparam logic [2:0] PH_Y    = 3'b010;
    localparam logic [2:0] PH_R    = 3'b100;

    localparam logic [3:0] DEF_G_T = 4'd10;
    localparam logic [3:0] DEF_Y_T = 4'd5;
    localparam logic [3:0] DEF_R_T = 4'd15;
    localparam logic [3:0] T_MIN   = 4'd1;
    localparam logic [3:0] T_TEN   = 4'd10;

    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'd0,
        CTRL_PHASE   = 2'd1,
        CTRL_ILLEGAL = 2'd2
    } ctrl_kind_e;

    function automatic ctrl_kind_e classify_ctrl(input logic [2:0] code);
        ctrl_kind_e kind;
        case (code)
            PH_IDLE:             kind = CTRL_IDLE;
            PH_G, PH_Y, PH_R:    kind = CTRL_PHASE;
            default:             kind = CTRL_ILLEGAL;
        endcase
        return kind;
    endfunction

    // A zero duration would make the phase unobservable, so it runs as 1 s.
    function automatic logic [3:0] clamp_dur(input logic [3:0] dur);
        return (dur == 4'd0) ? T_MIN : dur;
    endfunction

endpackage

// File: rtl/traffic_phase_timer_tick_sync.sv
// tick_sync: brings the slow 1 Hz level into sys_clk and emits a one-cycle
// tick two edges after a rising level is first sampled.
module tick_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic slow_lvl,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic lvl_prev_q, lvl_prev_d;
    logic tick_q, tick_d;

    // lvl_prev resets low, so a level already high at reset release is
    // only treated as an edge once it has passed through as a low first.
    always_comb begin
        sync1_d    = slow_lvl;
        sync2_d    = sync1_q;
        lvl_prev_d = sync2_q;
        tick_d     = sync2_q & ~lvl_prev_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            lvl_prev_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_prev_q <= lvl_prev_d;
            tick_q     <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase countdown for the traffic light controller; sys_rst_n is active-high.
// Optional BCD display outputs are built when TRAFFIC_TIMER_BCD_EN is defined.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter logic [3:0] G_T = DEF_G_T,
    parameter logic [3:0] Y_T = DEF_Y_T,
    parameter logic [3:0] R_T = DEF_R_T
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sys_clk_1s,
    input  logic [2:0] light_ctrl,
    output logic [3:0] light_t,
    output logic       phase_done,
    output logic       ctrl_err
`ifdef TRAFFIC_TIMER_BCD_EN
    ,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones
`endif
);

    logic       tick;
    logic [2:0] ctrl_q, ctrl_d;
    logic [3:0] light_t_q, light_t_d;
    logic       phase_done_q, phase_done_d;
    logic       ctrl_err_q, ctrl_err_d;
    logic       phase_change;
    logic [3:0] load_val;
    ctrl_kind_e kind_new;
    ctrl_kind_e kind_held;

    tick_sync u_tick_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .slow_lvl  (sys_clk_1s),
        .tick      (tick)
    );

    always_comb begin
        case (light_ctrl)
            PH_G:    load_val = clamp_dur(G_T);
            PH_Y:    load_val = clamp_dur(Y_T);
            PH_R:    load_val = clamp_dur(R_T);
            default: load_val = T_MIN;
        endcase
    end

    // A load always beats a coincident tick; IDLE and illegal codes sit at 1.
    always_comb begin
        kind_new     = classify_ctrl(light_ctrl);
        kind_held    = classify_ctrl(ctrl_q);
        phase_change = (light_ctrl != ctrl_q);
        ctrl_d       = light_ctrl;
        light_t_d    = light_t_q;
        phase_done_d = 1'b0;
        ctrl_err_d   = ctrl_err_q;

        if (kind_new == CTRL_ILLEGAL) begin
            ctrl_err_d = 1'b1;
        end

        if (phase_change) begin
            light_t_d = load_val;
        end else if (tick && (kind_held == CTRL_PHASE) && (light_t_q > T_MIN)) begin
            light_t_d    = light_t_q - 4'd1;
            phase_done_d = (light_t_q == 4'd2);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            ctrl_q       <= PH_IDLE;
            light_t_q    <= T_MIN;
            phase_done_q <= 1'b0;
            ctrl_err_q   <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            light_t_q    <= light_t_d;
            phase_done_q <= phase_done_d;
            ctrl_err_q   <= ctrl_err_d;
        end
    end

    assign light_t    = light_t_q;
    assign phase_done = phase_done_q;
    assign ctrl_err   = ctrl_err_q;

`ifdef TRAFFIC_TIMER_BCD_EN
    logic [3:0] disp_tens_q, disp_tens_d;
    logic [3:0] disp_ones_q, disp_ones_d;

    always_comb begin
        if (light_t_q >= T_TEN) begin
            disp_tens_d = 4'd1;
            disp_ones_d = light_t_q - T_TEN;
        end else begin
            disp_tens_d = 4'd0;
            disp_ones_d = light_t_q;
        end
    end

    // Reset values match the BCD of the reset count (01).
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            disp_tens_q <= 4'd0;
            disp_ones_q <= 4'd1;
        end else begin
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
        end
    end

    assign disp_tens = disp_tens_q;
    assign disp_ones = disp_ones_q;
`endif

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Scoreboard bench for traffic_phase_timer: a behavioural model pushes the
// expected outputs each clock, a negedge monitor pops and compares them.
module tb_traffic_phase_timer;

    localparam int G_DUR = 10;
    localparam int Y_DUR = 5;
    localparam int R_DUR = 15;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       sys_clk_1s;
    logic [2:0] light_ctrl;
    logic [3:0] light_t;
    logic       phase_done;
    logic       ctrl_err;
`ifdef TRAFFIC_TIMER_BCD_EN
    logic [3:0] disp_tens;
    logic [3:0] disp_ones;
`endif

    traffic_phase_timer dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sys_clk_1s (sys_clk_1s),
        .light_ctrl (light_ctrl),
        .light_t    (light_t),
        .phase_done (phase_done),
        .ctrl_err   (ctrl_err)
`ifdef TRAFFIC_TIMER_BCD_EN
        ,
        .disp_tens  (disp_tens),
        .disp_ones  (disp_ones)
`endif
    );

    typedef struct {
        int t;
        int done;
        int err;
        int disp;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_seen = 0;

    // reference model state
    int       m_t = 1;
    int       m_done = 0;
    int       m_err = 0;
    int       m_disp = 1;
    int       m_ctrl = 0;
    bit [3:0] m_hist = '0;
    bit       m_tick_now = 1'b0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        sys_clk_1s = 1'b0;
        forever begin
            repeat ($urandom_range(2, 6)) @(negedge sys_clk);
            sys_clk_1s = ~sys_clk_1s;
        end
    end

    function automatic int dur_of(input int c);
        int d;
        case (c)
            1:       d = G_DUR;
            2:       d = Y_DUR;
            4:       d = R_DUR;
            default: d = 1;
        endcase
        return (d == 0) ? 1 : d;
    endfunction

    function automatic void cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: a 1 Hz rising edge sampled at edge n decrements at edge n+3.
    always @(posedge sys_clk) begin
        exp_t e;
        int   c;
        bit   tick;
        int   prev_t;
        if (sys_rst_n) begin
            m_t = 1; m_done = 0; m_err = 0; m_ctrl = 0; m_disp = 1;
            m_hist = '0;
        end else begin
            c      = int'(light_ctrl);
            tick   = m_hist[2] && !m_hist[3];
            prev_t = m_t;
            m_done = 0;
            if (c != m_ctrl) begin
                m_t = dur_of(c);
            end else if (tick && m_t > 1) begin
                m_done = (m_t == 2) ? 1 : 0;
                m_t    = m_t - 1;
            end
            if ($countones(light_ctrl) > 1) m_err = 1;
            m_ctrl = c;
            m_disp = prev_t;
            m_hist = {m_hist[2:0], sys_clk_1s};
        end
        m_tick_now = m_hist[2] && !m_hist[3];
        e.t = m_t; e.done = m_done; e.err = m_err; e.disp = m_disp;
        sbq.push_back(e);
    end

    always @(negedge sys_clk) begin
        exp_t e;
        if (phase_done) done_seen++;
        if (sbq.size() == 0) begin
            cmp("sb_underflow", 0, 1);
        end else begin
            e = sbq.pop_front();
            cmp("light_t", int'(light_t), e.t);
            cmp("phase_done", int'(phase_done), e.done);
            cmp("ctrl_err", int'(ctrl_err), e.err);
`ifdef TRAFFIC_TIMER_BCD_EN
            cmp("disp_tens", int'(disp_tens), e.disp / 10);
            cmp("disp_ones", int'(disp_ones), e.disp % 10);
`endif
        end
    end

    task automatic wait_ticks(input int n, input string nm);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n && cyc < 400) begin
            if (m_tick_now) cnt++;
            @(negedge sys_clk);
            cyc++;
        end
        #1;
        if (cnt < n) cmp({nm, "_timeout"}, cnt, n);
    endtask

    task automatic wait_tick_cycle(input string nm);
        int cyc = 0;
        while (!m_tick_now && cyc < 400) begin
            @(negedge sys_clk);
            cyc++;
        end
        if (!m_tick_now) cmp({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_model_t(input int v, input string nm);
        int cyc = 0;
        while (m_t != v && cyc < 600) begin
            @(negedge sys_clk);
            cyc++;
        end
        if (m_t != v) cmp({nm, "_timeout"}, m_t, v);
    endtask

    initial begin
        sys_rst_n  = 1'b1;
        light_ctrl = 3'b000;
        repeat (3) @(negedge sys_clk);
        #1;
        cmp("rst_light_t", int'(light_t), 1);
        cmp("rst_phase_done", int'(phase_done), 0);
        cmp("rst_ctrl_err", int'(ctrl_err), 0);
        #1 sys_rst_n = 1'b0;

        // idle holds at 1 through ticks
        @(negedge sys_clk);
        done_seen = 0;
        wait_ticks(5, "idle_ticks");
        cmp("idle_light_t", int'(light_t), 1);
        cmp("idle_done_cnt", done_seen, 0);

        // green countdown 10..1, single pulse, then hold
        light_ctrl = 3'b001;
        @(negedge sys_clk);
        #1;
        cmp("g_load", int'(light_t), 10);
        done_seen = 0;
        wait_ticks(9, "g_ticks");
        cmp("g_end_t", int'(light_t), 1);
        cmp("g_done_cnt", done_seen, 1);
        wait_ticks(1, "g_hold");
        cmp("g_hold_t", int'(light_t), 1);
        cmp("g_hold_done_cnt", done_seen, 1);

        // phase change coincident with a tick: load wins
        light_ctrl = 3'b000;
        @(negedge sys_clk);
        light_ctrl = 3'b001;
        @(negedge sys_clk);
        wait_ticks(1, "pre_coinc");
        wait_tick_cycle("coinc");
        light_ctrl = 3'b010;
        @(negedge sys_clk);
        #1;
        cmp("coinc_y_load", int'(light_t), 5);

        // illegal code then red
        light_ctrl = 3'b011;
        @(negedge sys_clk);
        #1;
        cmp("ill_light_t", int'(light_t), 1);
        cmp("ill_ctrl_err", int'(ctrl_err), 1);
        wait_ticks(2, "ill_hold");
        cmp("ill_hold_t", int'(light_t), 1);
        light_ctrl = 3'b100;
        @(negedge sys_clk);
        #1;
        cmp("r_load", int'(light_t), 15);
        cmp("r_err_sticky", int'(ctrl_err), 1);

`ifdef TRAFFIC_TIMER_BCD_EN
        wait_model_t(12, "bcd");
        #1;
        cmp("bcd_light_t", int'(light_t), 12);
        @(negedge sys_clk);
        #1;
        cmp("bcd_tens", int'(disp_tens), 1);
        cmp("bcd_ones", int'(disp_ones), 2);
`endif

        // async reset mid-countdown in red
        wait_model_t(7, "r_to_7");
        #2;
        cmp("pre_rst_t", int'(light_t), 7);
        sys_rst_n = 1'b1;
        #1;
        cmp("async_rst_t", int'(light_t), 1);
        cmp("async_rst_err", int'(ctrl_err), 0);
        repeat (3) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        #1;
        cmp("post_rst_load", int'(light_t), 15);

        // randomized phase sequences with occasional illegal codes and resets
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 4) == 0)
                light_ctrl = 3'($urandom_range(0, 7));
            else
                case ($urandom_range(0, 3))
                    0: light_ctrl = 3'b000;
                    1: light_ctrl = 3'b001;
                    2: light_ctrl = 3'b010;
                    default: light_ctrl = 3'b100;
                endcase
            repeat ($urandom_range(1, 40)) @(negedge sys_clk);
            if ($urandom_range(0, 29) == 0) begin
                #2 sys_rst_n = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge sys_clk);
                #2 sys_rst_n = 1'b0;
                @(negedge sys_clk);
            end
        end

        repeat (3) @(negedge sys_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
